// File: rtl/mem_access_arbiter.sv
// Shares one memory port between an instruction-fetch requester and a data requester.
// Arbitration is round-robin by default; define DATA_PRIORITY_EN for fixed data priority.
module mem_access_arbiter #(
    parameter int unsigned MEMORY_DEPTH = 64,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_req_i,
    input  logic [MEMORY_DEPTH-1:0] if_addr_i,
    output logic                    if_gnt_o,
    output logic                    if_valid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    input  logic                    d_req_i,
    input  logic                    d_we_i,
    input  logic [MEMORY_DEPTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    output logic                    d_gnt_o,
    output logic                    d_valid_o,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,
    output logic [MEMORY_DEPTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic                    mem_we_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e                  state, state_n;
    logic                    sel_data, sel_data_n;
    logic                    pick_d;
    logic                    if_gnt_n, if_valid_n, d_gnt_n, d_valid_n;
    logic                    mem_we_n, busy_n;
    logic [DATA_WIDTH-1:0]   if_rdata_n, d_rdata_n, mem_wdata_n;
    logic [MEMORY_DEPTH-1:0] mem_addr_n;
`ifndef DATA_PRIORITY_EN
    logic                    last_owner, last_owner_n;
`endif

    // Winner selection for a request seen in IDLE
    always_comb begin
        pick_d = 1'b0;
`ifdef DATA_PRIORITY_EN
        pick_d = d_req_i;
`else
        // last_owner == 1 means the data port was granted last
        pick_d = d_req_i && (!if_req_i || !last_owner);
`endif
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        sel_data_n  = sel_data;
        if_gnt_n    = 1'b0;
        if_valid_n  = 1'b0;
        d_gnt_n     = 1'b0;
        d_valid_n   = 1'b0;
        mem_we_n    = 1'b0;
        if_rdata_n  = if_rdata_o;
        d_rdata_n   = d_rdata_o;
        mem_addr_n  = mem_addr_o;
        mem_wdata_n = mem_wdata_o;
`ifndef DATA_PRIORITY_EN
        last_owner_n = last_owner;
`endif
        unique case (state)
            IDLE: begin
                if (if_req_i || d_req_i) begin
                    state_n    = ACCESS;
                    sel_data_n = pick_d;
`ifndef DATA_PRIORITY_EN
                    last_owner_n = pick_d;
`endif
                    if (pick_d) begin
                        d_gnt_n    = 1'b1;
                        mem_addr_n = d_addr_i;
                        if (d_we_i) begin
                            mem_wdata_n = d_wdata_i;
                            mem_we_n    = 1'b1;
                        end
                    end else begin
                        if_gnt_n   = 1'b1;
                        mem_addr_n = if_addr_i;
                    end
                end
            end
            ACCESS: begin
                // mem_we_o high here marks a data write committing this cycle
                if (mem_we_o) begin
                    d_valid_n = 1'b1;
                    state_n   = IDLE;
                end else begin
                    state_n = RESP;
                end
            end
            RESP: begin
                state_n = IDLE;
                if (sel_data) begin
                    d_rdata_n = mem_rdata_i;
                    d_valid_n = 1'b1;
                end else begin
                    if_rdata_n = mem_rdata_i;
                    if_valid_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel_data    <= 1'b0;
            if_gnt_o    <= 1'b0;
            if_valid_o  <= 1'b0;
            if_rdata_o  <= '0;
            d_gnt_o     <= 1'b0;
            d_valid_o   <= 1'b0;
            d_rdata_o   <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_we_o    <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state       <= state_n;
            sel_data    <= sel_data_n;
            if_gnt_o    <= if_gnt_n;
            if_valid_o  <= if_valid_n;
            if_rdata_o  <= if_rdata_n;
            d_gnt_o     <= d_gnt_n;
            d_valid_o   <= d_valid_n;
            d_rdata_o   <= d_rdata_n;
            mem_addr_o  <= mem_addr_n;
            mem_wdata_o <= mem_wdata_n;
            mem_we_o    <= mem_we_n;
            busy_o      <= busy_n;
        end
    end

`ifndef DATA_PRIORITY_EN
    // Reset to data so fetch wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_owner <= 1'b1;
        else        last_owner <= last_owner_n;
    end
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed self-checking bench for mem_access_arbiter with a small ROM/RAM model.
// ROM occupies 0x00-0x3F (word = 0x1000_0000 | addr); RAM above (init 0xA5A5_0000 | addr).
module tb_mem_access_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, if_gnt, if_valid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_valid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we, busy;

    int ncmp = 0;
    int nfail = 0;

    mem_access_arbiter #(.MEMORY_DEPTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_valid_o(if_valid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt), .d_valid_o(d_valid), .d_rdata_o(d_rdata),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
        .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Memory model: registered address, write at the clock edge, ROM region read-only
    logic [DW-1:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = (i < 64) ? (32'h1000_0000 | 32'(i)) : (32'hA5A5_0000 | 32'(i));
    end
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[7:0]];
        if (mem_we && mem_addr[7:0] >= 8'h40) mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy !== 1'b0 && c < 20) begin
            tick();
            c++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    int           n, ng, nv;
    logic         seq [0:3];
    int           gc  [0:2];
    logic [DW-1:0] vd [0:2];

    initial begin
        rst_n = 1'b0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 4; i++) seq[i] = 1'bx;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_if_rdata", 64'(if_rdata), 64'd0);
        chk("rst_gnts", 64'({if_gnt, d_gnt, if_valid, d_valid}), 64'd0);
        tick(); rst_n = 1'b1; tick();

        // Fetch read at 0x4
        if_req = 1; if_addr = 64'h4;
        tick();
        chk("f4_gnt", 64'(if_gnt), 64'd1);
        chk("f4_busy1", 64'(busy), 64'd1);
        chk("f4_addr", mem_addr, 64'h4);
        if_req = 0;
        tick();
        chk("f4_gnt_pulse", 64'(if_gnt), 64'd0);
        chk("f4_busy2", 64'(busy), 64'd1);
        chk("f4_novalid", 64'(if_valid), 64'd0);
        tick();
        chk("f4_valid", 64'(if_valid), 64'd1);
        chk("f4_rdata", 64'(if_rdata), 64'h1000_0004);
        chk("f4_busy3", 64'(busy), 64'd0);
        tick();
        chk("f4_valid_pulse", 64'(if_valid), 64'd0);

        // Data write 0xDEADBEEF to 0x40, then read back
        d_req = 1; d_we = 1; d_addr = 64'h40; d_wdata = 32'hDEAD_BEEF;
        tick();
        chk("w40_gnt", 64'(d_gnt), 64'd1);
        chk("w40_we", 64'(mem_we), 64'd1);
        chk("w40_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        d_req = 0; d_we = 0;
        tick();
        chk("w40_we_off", 64'(mem_we), 64'd0);
        chk("w40_ack", 64'(d_valid), 64'd1);
        chk("w40_rdata_hold", 64'(d_rdata), 64'd0);
        chk("w40_busy", 64'(busy), 64'd0);
        d_req = 1;
        tick();
        chk("r40_gnt", 64'(d_gnt), 64'd1);
        chk("r40_we", 64'(mem_we), 64'd0);
        d_req = 0;
        tick(); tick();
        chk("r40_valid", 64'(d_valid), 64'd1);
        chk("r40_rdata", 64'(d_rdata), 64'hDEAD_BEEF);
        tick();

        // Simultaneous requests held for four grants
        if_req = 1; if_addr = 64'h8; d_req = 1; d_we = 0; d_addr = 64'h44;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if (if_gnt) begin seq[n] = 1'b0; n++; end
            else if (d_gnt) begin seq[n] = 1'b1; n++; end
        end
        if_req = 0; d_req = 0;
        chk("rr_count", 64'(n), 64'd4);
`ifdef DATA_PRIORITY_EN
        chk("rr_g0", 64'(seq[0]), 64'd1);
        chk("rr_g1", 64'(seq[1]), 64'd1);
        chk("rr_g2", 64'(seq[2]), 64'd1);
        chk("rr_g3", 64'(seq[3]), 64'd1);
`else
        chk("rr_g0", 64'(seq[0]), 64'd0);
        chk("rr_g1", 64'(seq[1]), 64'd1);
        chk("rr_g2", 64'(seq[2]), 64'd0);
        chk("rr_g3", 64'(seq[3]), 64'd1);
`endif
        wait_idle();
        tick();

        // Back-to-back fetches 0x0, 0x1, 0x2 with request held high
        if_req = 1; if_addr = 64'h0;
        ng = 0; nv = 0;
        for (int c = 0; c < 40 && nv < 3; c++) begin
            tick();
            if (if_gnt && ng < 3) begin
                gc[ng] = c; ng++;
                if (ng < 3) if_addr = 64'(ng);
                else if_req = 0;
            end
            if (if_valid && nv < 3) begin vd[nv] = if_rdata; nv++; end
        end
        if_req = 0;
        chk("b2b_grants", 64'(ng), 64'd3);
        chk("b2b_valids", 64'(nv), 64'd3);
        chk("b2b_gap01", 64'(gc[1] - gc[0]), 64'd3);
        chk("b2b_gap12", 64'(gc[2] - gc[1]), 64'd3);
        chk("b2b_d0", 64'(vd[0]), 64'h1000_0000);
        chk("b2b_d1", 64'(vd[1]), 64'h1000_0001);
        chk("b2b_d2", 64'(vd[2]), 64'h1000_0002);
        wait_idle();
        tick();

        // Reset asserted during ACCESS of a write to 0x41
        d_req = 1; d_we = 1; d_addr = 64'h41; d_wdata = 32'h1234_5678;
        tick();
        chk("rw_gnt", 64'(d_gnt), 64'd1);
        chk("rw_we", 64'(mem_we), 64'd1);
        rst_n = 0; d_req = 0; d_we = 0;
        #1;
        chk("rw_async_we", 64'(mem_we), 64'd0);
        chk("rw_async_busy", 64'(busy), 64'd0);
        chk("rw_async_addr", mem_addr, 64'd0);
        chk("rw_async_d_rdata", 64'(d_rdata), 64'd0);
        tick();
        rst_n = 1;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (d_valid) n++;
        end
        chk("rw_no_valid", 64'(n), 64'd0);
        d_req = 1;
        tick();
        chk("rw_rd_gnt", 64'(d_gnt), 64'd1);
        d_req = 0;
        tick(); tick();
        chk("rw_rd_valid", 64'(d_valid), 64'd1);
        chk("rw_old_value", 64'(d_rdata), 64'hA5A5_0041);
        tick();

        // Data write then a fetch raised while the write is in flight
        d_req = 1; d_we = 1; d_addr = 64'h42; d_wdata = 32'hCAFE_F00D;
        tick();
        chk("wf_dgnt", 64'(d_gnt), 64'd1);
        d_req = 0; d_we = 0; if_req = 1; if_addr = 64'h5;
        tick();
        chk("wf_ack", 64'(d_valid), 64'd1);
        chk("wf_rdata_hold", 64'(d_rdata), 64'hA5A5_0041);
        chk("wf_no_fgnt_yet", 64'(if_gnt), 64'd0);
        tick();
        chk("wf_fgnt", 64'(if_gnt), 64'd1);
        chk("wf_faddr", mem_addr, 64'h5);
        if_req = 0;
        tick(); tick();
        chk("wf_fvalid", 64'(if_valid), 64'd1);
        chk("wf_frdata", 64'(if_rdata), 64'h1000_0005);
        chk("wf_d_rdata_still", 64'(d_rdata), 64'hA5A5_0041);
        chk("wf_ram_written", 64'(mem[8'h42]), 64'hCAFE_F00D);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares the single memory system port (ROM/RAM with address-based select) between two requesters: an instruction-fetch port (read-only) and a data port (read/write).
- Serialises accesses with an FSM and drives the memory system's address, write-data and write-enable inputs.
- Returns read data with a one-cycle valid pulse to the winning requester.
- Sits between the core's fetch/load-store units and the memory system.

Parameters:
- MEMORY_DEPTH, 64, width of the address bus (matches the memory system address input width).
- DATA_WIDTH, 32, data word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req_i  in  1  fetch request; held with if_addr_i until if_gnt_o.
- if_addr_i  in  MEMORY_DEPTH  fetch address.
- if_gnt_o  out  1  fetch request accepted (1-cycle pulse).
- if_valid_o  out  1  if_rdata_o valid (1-cycle pulse).
- if_rdata_o  out  DATA_WIDTH  fetched word.
- d_req_i  in  1  data request; held with address/we/wdata until d_gnt_o.
- d_we_i  in  1  1 = write, 0 = read.
- d_addr_i  in  MEMORY_DEPTH  data address.
- d_wdata_i  in  DATA_WIDTH  write data.
- d_gnt_o  out  1  data request accepted (1-cycle pulse).
- d_valid_o  out  1  read data valid, or write acknowledged (1-cycle pulse).
- d_rdata_o  out  DATA_WIDTH  read word; holds its previous value on write acks.
- mem_addr_o  out  MEMORY_DEPTH  to memory system Address_i.
- mem_wdata_o  out  DATA_WIDTH  to memory system Write_Data_i.
- mem_we_o  out  1  to memory system Write_Enable_i.
- mem_rdata_i  in  DATA_WIDTH  from memory system Instruction_o.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0 (gnt, valid, rdata, mem_addr, mem_wdata, mem_we, busy). last_owner=DATA, so the fetch port wins the first tie.
- All outputs are registered.
- States:
  - IDLE: sample requests and pick a winner.
  - ACCESS: address on memory bus; a write commits at the end of this cycle.
  - RESP: read data present on mem_rdata_i.
- Memory read latency is 1 cycle after the address is presented (RAM registers the address).
- Timeline, request sampled high in IDLE at cycle T:
  - End of T: latch winner's addr into mem_addr_o. For a data write, also latch wdata into mem_wdata_o and set mem_we_o=1. Pulse winner's gnt in T+1. Go to ACCESS.
  - T+1 (ACCESS): mem_we_o high for exactly this cycle.
    - Write: go to IDLE; d_valid_o pulses in T+2.
    - Read: go to RESP.
  - T+2 (RESP): capture mem_rdata_i into the winner's rdata_o; valid pulses in T+3; go to IDLE.
- Throughput and latency:
  - Read: gnt at T+1, valid at T+3, new request accepted at T+3 (one read per 3 cycles).
  - Write: ack at T+2, next accept at T+2.
- Arbitration (macro undefined): round-robin. On a simultaneous request the port that is not last_owner wins; last_owner updates on every grant. A single requester always wins.
- Requests are sampled only in IDLE. A req held high through gnt counts as a new request at the next IDLE.
- The losing requester keeps req asserted and is served next with no lost request.
- mem_addr_o and mem_wdata_o hold their last values in IDLE. mem_we_o is 0 outside ACCESS-for-write.
- rdata_o of each port holds its value until that port's next read completes.
- Reset mid-operation: the FSM aborts to IDLE immediately. A pending write whose ACCESS edge has not occurred is not committed, and no valid pulse follows.
- Address or ROM/RAM region is not checked; writes to the ROM region are passed through and ignored by the memory system.

Optional Feature:
- Macro DATA_PRIORITY_EN.
- Defined: fixed priority. The data port always wins a simultaneous request, and last_owner is unused.
- Undefined: round-robin as above.
- Timing is identical in both builds.

Test Plan:
- Reset, then fetch read at addr 0x4 → if_gnt_o pulse at T+1, if_valid_o at T+3, if_rdata_o = ROM word 0x4, busy_o high T+1..T+2.
- Data write 0xDEADBEEF to RAM addr 0x40, then data read of 0x40 → mem_we_o high exactly 1 cycle, d_valid_o at T+2, read returns 0xDEADBEEF.
- if_req_i and d_req_i held high together for 4 accesses → grant order IF, D, IF, D; with DATA_PRIORITY_EN → D, D, D, D while d_req_i stays high.
- Back-to-back fetches at 0x0, 0x1, 0x2 with req held high → grants 3 cycles apart, rdata values in order, no dropped request.
- rst_n pulled low during ACCESS of a write to 0x41 → outputs 0 asynchronously, later read of 0x41 returns the old value, no d_valid_o.
- Data write followed by a simultaneous fetch → d_rdata_o unchanged by the write ack, fetch served at T+2 after the write ack.
